// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for shift_add_multiplier.
// master = operand producer / result consumer, slave = multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                 valid_data;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 ack;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [CW-1:0]        cycles;

    modport master (
        output valid_data, a, b, is_signed, ack,
        input  busy, done, product, cycles
    );

    modport slave (
        input  valid_data, a, b, is_signed, ack,
        output busy, done, product, cycles
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are multiplied as magnitudes and the sign is applied
// once on the way into the product register.
module shift_add_multiplier #(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_multiplier_if.slave io
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mc;
    logic [WIDTH-1:0]   mp;
    logic [2*WIDTH-1:0] p;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      cycles;

    logic [2*WIDTH-1:0] p_add;
    logic [WIDTH-1:0]   mp_sh;
    logic [CW-1:0]      cnt_nx;
    logic               last;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    // One iteration's worth of datapath, plus operand magnitudes for capture.
    // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
    always_comb begin
        p_add  = mp[0] ? (p + mc) : p;
        mp_sh  = mp >> 1;
        cnt_nx = cnt + 1'b1;
        last   = (cnt_nx == CW'(WIDTH)) || ((EARLY_TERM != 0) && (mp_sh == '0));
        a_abs  = (io.is_signed && io.a[WIDTH-1]) ? -io.a : io.a;
        b_abs  = (io.is_signed && io.b[WIDTH-1]) ? -io.b : io.b;
    end

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mc      <= '0;
            mp      <= '0;
            p       <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            cycles  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.valid_data) begin
                        mc    <= {{WIDTH{1'b0}}, a_abs};
                        mp    <= b_abs;
                        neg   <= io.is_signed & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
                        p     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    p   <= p_add;
                    mc  <= mc << 1;
                    mp  <= mp_sh;
                    cnt <= cnt_nx;
                    if (last) begin
                        product <= neg ? -p_add : p_add;
                        cycles  <= cnt_nx;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // valid_data is deliberately ignored here, even alongside ack.
                    if (io.ack) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io.busy    = busy;
    assign io.done    = done;
    assign io.product = product;
    assign io.cycles  = cycles;

endmodule
